// File: rtl/led_pkg.sv
// led_pkg: shared mode and direction encodings for the LED chaser.
//   MODE_*  two-bit iMode values
//   DIR_*   oDir values
package led_pkg;
   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_RIGHT  = 2'b01;
   localparam logic [1:0] MODE_LEFT   = 2'b10;
   localparam logic [1:0] MODE_BOUNCE = 2'b11;
   localparam logic       DIR_RIGHT   = 1'b0;
   localparam logic       DIR_LEFT    = 1'b1;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that emits one tick every TICK_DIV enabled cycles.
//   iClk    clock
//   iRst_n  asynchronous active-low reset
//   iClr    synchronous clear of the count (wins over enable)
//   iEn     count enable; low holds the count and masks the tick
//   oTick   high during the last enabled cycle of each period
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iClr,
   input  logic iEn,
   output logic oTick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   logic [CW-1:0] cnt;
   assign oTick = iEn && (cnt == LAST);
   always_ff @(posedge iClk or negedge iRst_n)
      if (!iRst_n) cnt <= '0;
      else cnt <= iClr ? '0 : oTick ? '0 : iEn ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/led_chaser.sv
// led_chaser: prescaled LED pattern engine with hold, rotate and bounce modes.
//   iClk      clock
//   iRst_n    asynchronous active-low reset
//   iMode     00 hold, 01 rotate right, 10 rotate left, 11 bounce
//   iEn       run enable for prescaler and pattern
//   iLoad     synchronous load of iPattern, also restarts the prescaler
//   iPattern  value captured on iLoad
//   oLED      current pattern register
//   oTick     pulse on cycles where a step is due
//   oDir      current direction, 0 right, 1 left
module led_chaser
   import led_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int TICK_DIV = 50_000_000,
   parameter logic [WIDTH-1:0] INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic [1:0]       iMode,
   input  logic             iEn,
   input  logic             iLoad,
   input  logic [WIDTH-1:0] iPattern,
   output logic [WIDTH-1:0] oLED,
   output logic             oTick,
   output logic             oDir
);
   logic tick, goLeft, keep, nextDir;
   logic [WIDTH-1:0] nextPattern;
   tick_gen #(.TICK_DIV(TICK_DIV)) uTickGen (
      .iClk(iClk),
      .iRst_n(iRst_n),
      .iClr(iLoad),
      .iEn(iEn),
      .oTick(tick)
   );
   assign oTick = tick;
   // In bounce, reaching the edge that faces the current direction turns
   // around within the same tick, so the lit bit never dwells at an end.
   always_comb begin
      goLeft = (iMode == MODE_LEFT) ||
               (iMode == MODE_BOUNCE && (oDir ? !oLED[WIDTH-1] : oLED[0]));
      keep = iLoad || !tick || iMode == MODE_HOLD;
      nextPattern = iLoad ? iPattern : keep ? oLED :
                    goLeft ? {oLED[WIDTH-2:0], oLED[WIDTH-1]} : {oLED[0], oLED[WIDTH-1:1]};
      nextDir = keep ? oDir : goLeft;
   end
   always_ff @(posedge iClk or negedge iRst_n)
      if (!iRst_n) begin
         oLED <= INIT;
         oDir <= DIR_RIGHT;
      end else begin
         oLED <= nextPattern;
         oDir <= nextDir;
      end
endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: directed scenarios with a behavioural reference model checked every cycle.
module tb_led_chaser;
   localparam int W = 10;
   localparam int TD = 4;
   logic clk = 0, rst_n = 0, en = 1, load = 0;
   logic [1:0] mode = 2'b01;
   logic [W-1:0] pat = '0, led;
   logic tick, dir;
   int nTests = 0, nFail = 0;
   always #5 clk = ~clk;
   led_chaser #(.WIDTH(W), .TICK_DIV(TD)) dut (
      .iClk(clk), .iRst_n(rst_n), .iMode(mode), .iEn(en), .iLoad(load),
      .iPattern(pat), .oLED(led), .oTick(tick), .oDir(dir)
   );
   task automatic check(input string name, input int got, input int exp);
      nTests++;
      if (got != exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   // Reference model: integer prescale count, pattern as a ring of W lamps.
   int mCnt;
   logic [W-1:0] mPat;
   logic mDir;
   function automatic logic [W-1:0] ringMove(input logic [W-1:0] p, input logic left);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = left ? p[(i + W - 1) % W] : p[(i + 1) % W];
      return r;
   endfunction
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mCnt <= 0;
         mPat <= 1;
         mDir <= 0;
      end else if (load) begin
         mPat <= pat;
         mCnt <= 0;
      end else if (en) begin
         mCnt <= (mCnt + 1) % TD;
         if (mCnt == TD - 1 && mode != 2'b00) begin
            automatic logic d = (mode == 2'b01) ? 1'b0 : (mode == 2'b10) ? 1'b1 :
                                ((mDir ? mPat[W-1] : mPat[0]) ? !mDir : mDir);
            mDir <= d;
            mPat <= ringMove(mPat, d);
         end
      end
   always @(negedge clk) begin
      check("model_led", int'(led), int'(mPat));
      check("model_dir", int'(dir), int'(mDir));
      check("model_tick", int'(tick), int'(en && mCnt == TD - 1));
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic waitTick(output int n);
      n = 0;
      while (!tick && n < 3 * TD) begin
         cyc();
         n++;
      end
      if (!tick) check("tick_timeout", 0, 1);
   endtask
   task automatic stepTo(input logic [W-1:0] exp, input int expWait, input string name);
      int n;
      waitTick(n);
      if (expWait >= 0) check({name, "_wait"}, n, expWait);
      cyc();
      check(name, int'(led), int'(exp));
   endtask
   task automatic doReset();
      rst_n = 0;
      #1;
      check("rst_led", int'(led), 'h001);
      check("rst_dir", int'(dir), 0);
      check("rst_tick", int'(tick), 0);
      #2 rst_n = 1;
      cyc();
   endtask
   initial begin
      int n, p;
      cyc();
      // rotate right from reset
      doReset();
      stepTo(10'h200, 2, "r1");
      check("r_dir", int'(dir), 0);
      stepTo(10'h100, 3, "r2");
      stepTo(10'h080, 3, "r3");
      // freeze with count at 2
      cyc();
      cyc();
      en = 0;
      #1 check("frz_tick", int'(tick), 0);
      repeat (7) cyc();
      check("frz_led", int'(led), 'h080);
      en = 1;
      stepTo(10'h040, 1, "resume");
      // load on a tick cycle
      waitTick(n);
      load = 1;
      pat = 10'h30F;
      #1 check("load_tick", int'(tick), 1);
      cyc();
      load = 0;
      check("load_led", int'(led), 'h30F);
      stepTo(10'h387, 3, "after_load");
      // all-zero pattern in bounce
      mode = 2'b11;
      load = 1;
      pat = '0;
      cyc();
      load = 0;
      stepTo('0, 3, "z1");
      stepTo('0, 3, "z2");
      check("z_dir", int'(dir), 0);
      // rotate left wraps after W ticks
      mode = 2'b10;
      doReset();
      stepTo(10'h002, 2, "l1");
      check("l_dir", int'(dir), 1);
      for (int i = 2; i < W; i++) stepTo(W'(1) << i, 3, "lseq");
      stepTo(10'h001, 3, "l_wrap");
      // bounce sweeps 0..W-1..0
      mode = 2'b11;
      doReset();
      for (int k = 1; k <= 20; k++) begin
         p = k % (2 * W - 2);
         if (p > W - 1) p = 2 * W - 2 - p;
         stepTo(W'(1) << p, -1, "bseq");
         if (k == 9) check("b_dir_top", int'(dir), 1);
         if (k == 10) check("b_dir_down", int'(dir), 0);
         if (k == 19) check("b_dir_up", int'(dir), 1);
      end
      // reset mid-sweep, restart like the first scenario
      mode = 2'b01;
      cyc();
      #2 doReset();
      stepTo(10'h200, 2, "rst_restart");
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
